// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: major opcodes, instruction field positions and the
// one-hot format bit order consumed by the immediate generator.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // One-hot format bit positions; order must match the immediate generator.
  localparam int FMT_R = 0;
  localparam int FMT_I = 1;
  localparam int FMT_S = 2;
  localparam int FMT_B = 3;
  localparam int FMT_U = 4;
  localparam int FMT_J = 5;
  localparam int FMT_W = 6;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  function automatic logic [FMT_W-1:0] fmt_bit(input int idx);
    logic [FMT_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decode_fmt.sv
// Purely combinational classifier: instruction word -> one-hot format,
// legality, register-operand usage and register fields.
module decode_fmt
  import rv32i_pkg::*;
(
  input  logic [31:0] inst,
  output logic [5:0]  format,
  output logic        illegal,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        is_load,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  logic [6:0] opcode;
  logic       unused_bits;

  assign opcode      = inst[OPC_MSB:OPC_LSB];
  assign rd          = inst[RD_MSB:RD_LSB];
  assign rs1         = inst[RS1_MSB:RS1_LSB];
  assign rs2         = inst[RS2_MSB:RS2_LSB];
  assign unused_bits = ^{inst[31:25], inst[14:12]};

  always_comb begin
    format  = fmt_bit(FMT_R);
    illegal = 1'b0;
    unique case (opcode)
      OP_REG:                                        format = fmt_bit(FMT_R);
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: format = fmt_bit(FMT_I);
      OP_STORE:                                      format = fmt_bit(FMT_S);
      OP_BRANCH:                                     format = fmt_bit(FMT_B);
      OP_LUI, OP_AUIPC:                              format = fmt_bit(FMT_U);
      OP_JAL:                                        format = fmt_bit(FMT_J);
      default: begin
        format  = fmt_bit(FMT_R);
        illegal = 1'b1;
      end
    endcase
    // Compressed or reserved encodings fall back to R and are flagged.
    if (inst[1:0] != 2'b11) begin
      format  = fmt_bit(FMT_R);
      illegal = 1'b1;
    end
  end

  assign uses_rs1 = format[FMT_R] | format[FMT_I] | format[FMT_S] | format[FMT_B];
  assign uses_rs2 = format[FMT_R] | format[FMT_S] | format[FMT_B];
  assign is_load  = (opcode == OP_LOAD);

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage sequencer: owns the IF/ID register, runs the fetch/EX
// handshakes, inserts load-use bubbles and kills wrong-path work on flush.
module decode_ctrl
  import rv32i_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_valid,
  input  logic [31:0] i_if_inst,
  input  logic [31:0] i_if_pc,
  output logic        o_if_ready,
  output logic        o_id_valid,
  input  logic        i_ex_ready,
  output logic [31:0] o_id_inst,
  output logic [31:0] o_id_pc,
  output logic [5:0]  o_id_format,
  output logic        o_id_illegal,
  input  logic        i_flush
);

  localparam logic [1:0] STALL_N = LOAD_USE_STALL[1:0];

  logic        vld_p1;
  logic [31:0] inst_p1;
  logic [31:0] pc_p1;
  logic        last_load;
  logic [4:0]  last_rd;
  logic [1:0]  bubble_cnt;
  logic [1:0]  bubble_nxt;

  logic [5:0]  format;
  logic        illegal;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        is_load;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  logic        hazard;
  logic        if_fire;
  logic        ex_fire;

  decode_fmt u_fmt (
    .inst     (inst_p1),
    .format   (format),
    .illegal  (illegal),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .is_load  (is_load),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2)
  );

  assign hazard = vld_p1 && last_load &&
                  ((uses_rs1 && (rs1 == last_rd)) || (uses_rs2 && (rs2 == last_rd)));

  assign o_id_valid   = vld_p1 && !hazard && !i_flush;
  assign ex_fire      = o_id_valid && i_ex_ready;
  // A flush frees ID this cycle; a concurrent fetch is handshaken and discarded.
  assign o_if_ready   = !vld_p1 || ex_fire || i_flush;
  assign if_fire      = i_if_valid && o_if_ready;

  assign o_id_inst    = inst_p1;
  assign o_id_pc      = pc_p1;
  assign o_id_format  = format;
  assign o_id_illegal = vld_p1 && illegal;

  assign bubble_nxt   = bubble_cnt + 2'd1;

  // IF -> ID stage boundary
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p1  <= 1'b0;
      inst_p1 <= '0;
      pc_p1   <= '0;
    end else if (i_flush) begin
      vld_p1  <= 1'b0;
    end else if (if_fire) begin
      vld_p1  <= 1'b1;
      inst_p1 <= i_if_inst;
      pc_p1   <= i_if_pc;
    end else if (ex_fire) begin
      vld_p1  <= 1'b0;
    end
  end

  // Load-use window: every EX advance without an instruction is one bubble.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_load  <= 1'b0;
      last_rd    <= '0;
      bubble_cnt <= '0;
    end else if (i_flush) begin
      last_load  <= 1'b0;
      bubble_cnt <= '0;
    end else if (ex_fire) begin
      if (is_load && (rd != 5'd0)) begin
        last_load  <= 1'b1;
        last_rd    <= rd;
        bubble_cnt <= '0;
      end else begin
        last_load  <= 1'b0;
      end
    end else if (i_ex_ready && last_load) begin
      if (bubble_nxt >= STALL_N) begin
        last_load  <= 1'b0;
        bubble_cnt <= '0;
      end else begin
        bubble_cnt <= bubble_nxt;
      end
    end
  end

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: scoreboard of accepted fetches checked as EX takes
// them, plus cycle-level checks of bubbles, backpressure, flush and reset.
module tb_decode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        if_valid = 1'b0;
  logic [31:0] if_inst = '0;
  logic [31:0] if_pc = '0;
  logic        if_ready;
  logic        id_valid;
  logic        ex_ready = 1'b1;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [5:0]  id_fmt;
  logic        id_illegal;
  logic        flush = 1'b0;

  logic        if_valid2 = 1'b0;
  logic [31:0] if_inst2 = '0;
  logic [31:0] if_pc2 = '0;
  logic        if_ready2;
  logic        id_valid2;
  logic        ex_ready2 = 1'b1;
  logic [31:0] id_inst2;
  logic [31:0] id_pc2;
  logic [5:0]  id_fmt2;
  logic        id_illegal2;
  logic        flush2 = 1'b0;

  always #5 clk = ~clk;

  decode_ctrl #(.LOAD_USE_STALL(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_if_valid(if_valid), .i_if_inst(if_inst),
    .i_if_pc(if_pc), .o_if_ready(if_ready), .o_id_valid(id_valid),
    .i_ex_ready(ex_ready), .o_id_inst(id_inst), .o_id_pc(id_pc),
    .o_id_format(id_fmt), .o_id_illegal(id_illegal), .i_flush(flush)
  );

  decode_ctrl #(.LOAD_USE_STALL(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_if_valid(if_valid2), .i_if_inst(if_inst2),
    .i_if_pc(if_pc2), .o_if_ready(if_ready2), .o_id_valid(id_valid2),
    .i_ex_ready(ex_ready2), .o_id_inst(id_inst2), .o_id_pc(id_pc2),
    .o_id_format(id_fmt2), .o_id_illegal(id_illegal2), .i_flush(flush2)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [5:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_fire = 0;
  int   base;

  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] LW_X0   = 32'h0000A003;
  localparam logic [31:0] ADD_DEP = 32'h00228333;
  localparam logic [31:0] ADD_X0  = 32'h00200333;
  localparam logic [31:0] SW_DEP  = 32'h00512223;
  localparam logic [31:0] LUI_X5  = 32'h000282B7;
  localparam logic [31:0] BEQ_DEP = 32'h00228063;
  localparam logic [31:0] ADDI_A  = 32'h00500093;
  localparam logic [31:0] ADDI_B  = 32'h00a00113;
  localparam logic [31:0] ADD_R   = 32'h002081b3;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference classification: {illegal, one-hot format [5]J..[0]R}.
  function automatic logic [6:0] model(input logic [31:0] w);
    logic [6:0] r;
    case (w[6:0])
      7'h33:                             r = 7'b0_000001;
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: r = 7'b0_000010;
      7'h23:                             r = 7'b0_000100;
      7'h63:                             r = 7'b0_001000;
      7'h37, 7'h17:                      r = 7'b0_010000;
      7'h6F:                             r = 7'b0_100000;
      default:                           r = 7'b1_000001;
    endcase
    if (w[1:0] != 2'b11) r = 7'b1_000001;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (id_valid && ex_ready) begin
        n_fire++;
        if (sb.size() == 0) begin
          chk_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk_eq("sb_inst", id_inst, e.inst);
          chk_eq("sb_pc", id_pc, e.pc);
          chk_eq("sb_fmt", {26'd0, id_fmt}, {26'd0, e.fmt});
          chk_eq("sb_illegal", {31'd0, id_illegal}, {31'd0, e.ill});
        end
      end
      if (if_valid && if_ready)
        sb.push_back('{inst: if_inst, pc: if_pc, fmt: model(if_inst)[5:0], ill: model(if_inst)[6]});
    end
  end

  task automatic cyc(input logic v, input logic [31:0] w, input logic [31:0] p,
                     input logic er, input logic fl);
    @(posedge clk);
    #1;
    if_valid = v; if_inst = w; if_pc = p; ex_ready = er; flush = fl;
    @(negedge clk);
  endtask

  task automatic cyc2(input logic v, input logic [31:0] w, input logic er);
    @(posedge clk);
    #1;
    if_valid2 = v; if_inst2 = w; if_pc2 = 32'h900; ex_ready2 = er;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk_eq("rst_id_valid", id_valid, 0);
    chk_eq("rst_if_ready", if_ready, 1);
    chk_eq("rst_fmt", id_fmt, 6'b000001);
    chk_eq("rst_illegal", id_illegal, 0);
    #10 rst = 1'b0;

    // back-to-back stream
    base = n_fire;
    cyc(1, ADDI_A, 32'h100, 1, 0);
    chk_eq("s0_valid", id_valid, 0); chk_eq("s0_ready", if_ready, 1);
    cyc(1, ADDI_B, 32'h104, 1, 0);
    chk_eq("s1_valid", id_valid, 1); chk_eq("s1_inst", id_inst, ADDI_A);
    chk_eq("s1_fmt", id_fmt, 6'b000010); chk_eq("s1_ready", if_ready, 1);
    cyc(1, ADD_R, 32'h108, 1, 0);
    chk_eq("s2_valid", id_valid, 1); chk_eq("s2_inst", id_inst, ADDI_B);
    chk_eq("s2_ready", if_ready, 1);
    idle();
    chk_eq("s3_valid", id_valid, 1); chk_eq("s3_fmt", id_fmt, 6'b000001);
    chk_eq("s3_inst", id_inst, ADD_R);
    idle();
    chk_eq("s4_valid", id_valid, 0);
    chk_eq("stream_fires", n_fire - base, 3);

    // load-use with LOAD_USE_STALL=1
    base = n_fire;
    cyc(1, LW_X5, 32'h200, 1, 0);
    cyc(1, ADD_DEP, 32'h204, 1, 0);
    chk_eq("lu_lw_valid", id_valid, 1);
    cyc(0, 32'd0, 32'd0, 1, 0);
    chk_eq("lu_bubble_valid", id_valid, 0); chk_eq("lu_bubble_ready", if_ready, 0);
    idle();
    chk_eq("lu_add_valid", id_valid, 1); chk_eq("lu_add_inst", id_inst, ADD_DEP);
    idle();
    chk_eq("lu_fires", n_fire - base, 2);

    // load to x0 creates no hazard
    cyc(1, LW_X0, 32'h210, 1, 0);
    cyc(1, ADD_X0, 32'h214, 1, 0);
    idle();
    chk_eq("x0_no_bubble", id_valid, 1); chk_eq("x0_inst", id_inst, ADD_X0);
    idle();

    // dependent store (rs2) and lui (no sources)
    cyc(1, LW_X5, 32'h220, 1, 0);
    cyc(1, SW_DEP, 32'h224, 1, 0);
    cyc(0, 32'd0, 32'd0, 1, 0);
    chk_eq("sw_bubble", id_valid, 0);
    idle();
    chk_eq("sw_valid", id_valid, 1); chk_eq("sw_fmt", id_fmt, 6'b000100);
    idle();
    cyc(1, LW_X5, 32'h230, 1, 0);
    cyc(1, LUI_X5, 32'h234, 1, 0);
    idle();
    chk_eq("lui_no_bubble", id_valid, 1); chk_eq("lui_fmt", id_fmt, 6'b010000);
    idle();

    // backpressure holds the instruction stable
    base = n_fire;
    cyc(1, ADDI_A, 32'h300, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'd0, 32'd0, 0, 0);
      chk_eq("bp_valid", id_valid, 1); chk_eq("bp_inst", id_inst, ADDI_A);
      chk_eq("bp_pc", id_pc, 32'h300); chk_eq("bp_ready", if_ready, 0);
    end
    idle();
    chk_eq("bp_release", id_valid, 1);
    idle();
    chk_eq("bp_fires", n_fire - base, 1);

    // LOAD_USE_STALL=2 with EX stalled inside the window
    cyc2(1, LW_X5, 1);
    cyc2(1, ADD_DEP, 1);
    chk_eq("d2_lw_valid", id_valid2, 1);
    cyc2(0, 32'd0, 0);
    chk_eq("d2_hold0", id_valid2, 0); chk_eq("d2_ready", if_ready2, 0);
    cyc2(0, 32'd0, 0);
    chk_eq("d2_hold1", id_valid2, 0);
    cyc2(0, 32'd0, 1);
    chk_eq("d2_bubble1", id_valid2, 0);
    cyc2(0, 32'd0, 1);
    chk_eq("d2_bubble2", id_valid2, 0);
    cyc2(0, 32'd0, 1);
    chk_eq("d2_add_valid", id_valid2, 1); chk_eq("d2_add_inst", id_inst2, ADD_DEP);
    cyc2(0, 32'd0, 1);
    chk_eq("d2_empty", id_valid2, 0);

    // flush with held B-type and a stale load hazard
    cyc(1, LW_X5, 32'h400, 1, 0);
    cyc(1, BEQ_DEP, 32'h404, 1, 0);
    cyc(1, ADDI_A, 32'h408, 1, 1);
    chk_eq("fl_valid", id_valid, 0); chk_eq("fl_ready", if_ready, 1);
    idle();
    chk_eq("fl_dropped", id_valid, 0);
    cyc(1, ADD_DEP, 32'h40c, 1, 0);
    idle();
    chk_eq("fl_no_stale", id_valid, 1); chk_eq("fl_inst", id_inst, ADD_DEP);
    idle();
    // flush forces valid low even without a hazard
    cyc(1, ADDI_A, 32'h500, 0, 0);
    cyc(1, ADDI_B, 32'h504, 1, 1);
    chk_eq("fl2_valid", id_valid, 0); chk_eq("fl2_ready", if_ready, 1);
    idle();
    chk_eq("fl2_dropped", id_valid, 0);

    // illegal encodings
    cyc(1, 32'h0000007F, 32'h600, 1, 0);
    idle();
    chk_eq("ill_fmt", id_fmt, 6'b000001); chk_eq("ill_flag", id_illegal, 1);
    cyc(1, 32'h00000010, 32'h604, 1, 0);
    idle();
    chk_eq("ill_lowbits", id_illegal, 1);
    idle();
    chk_eq("ill_masked", id_illegal, 0);

    // asynchronous reset in the middle of a load-use stall
    cyc(1, LW_X5, 32'h700, 1, 0);
    cyc(1, ADD_DEP, 32'h704, 1, 0);
    cyc(0, 32'd0, 32'd0, 1, 0);
    chk_eq("rs_stalled", id_valid, 0);
    rst = 1'b1;
    #1;
    chk_eq("rs_valid", id_valid, 0); chk_eq("rs_ready", if_ready, 1);
    chk_eq("rs_fmt", id_fmt, 6'b000001);
    #1;
    rst = 1'b0;
    sb.delete();
    cyc(1, ADD_DEP, 32'h708, 1, 0);
    chk_eq("rs_empty", id_valid, 0);
    idle();
    chk_eq("rs_no_bubble", id_valid, 1); chk_eq("rs_inst", id_inst, ADD_DEP);
    idle();
    idle();
    chk_eq("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
